// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the halt encoding and the fetch-stage
// state type, plus small arithmetic helpers used by the fetch stage.
package cpu_pkg;

    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned ADDR_W    = 8;
    localparam logic [WORD_SIZE-1:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam int unsigned FETCH_CNT_W = 16;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'd0,
        FS_RUN    = 2'd1,
        FS_HALTED = 2'd2
    } fetch_state_t;

    // Word addresses wrap modulo 2^ADDR_W; 255 + 1 is simply 0.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + 1'b1;
    endfunction

    function automatic logic [FETCH_CNT_W-1:0] sat_inc(input logic [FETCH_CNT_W-1:0] cnt);
        return (cnt == {FETCH_CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and loads
// the IF/ID register, with stall/flush/redirect, start handshake and halt.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [ADDR_W-1:0]      instr_read_address,
    input  logic [WORD_SIZE-1:0]   instr_instruction,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_target,
    output logic [WORD_SIZE-1:0]   ifid_instr,
    output logic [ADDR_W-1:0]      ifid_pc,
    output logic [ADDR_W-1:0]      ifid_pc_plus1,
    output logic                   ifid_valid,
    output logic                   running,
    output logic                   halted,
    output logic [FETCH_CNT_W-1:0] fetch_count
);

    fetch_state_t           r_state;
    logic [ADDR_W-1:0]      r_pc;
    logic [WORD_SIZE-1:0]   r_ifid_instr;
    logic [ADDR_W-1:0]      r_ifid_pc;
    logic [ADDR_W-1:0]      r_ifid_pc_plus1;
    logic                   r_ifid_valid;
    logic [FETCH_CNT_W-1:0] r_fetch_count;

    logic [ADDR_W-1:0]      w_pc_plus1;
    logic                   w_is_halt;

    assign w_pc_plus1 = pc_inc(r_pc);
    assign w_is_halt  = (instr_instruction == HALT_WORD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= FS_IDLE;
            r_pc            <= RESET_PC;
            r_ifid_instr    <= '0;
            r_ifid_pc       <= '0;
            r_ifid_pc_plus1 <= '0;
            r_ifid_valid    <= 1'b0;
            r_fetch_count   <= '0;
        end else begin
            case (r_state)
                FS_IDLE: begin
                    r_ifid_valid <= 1'b0;
                    // A redirect while idle sets the boot address.
                    if (redirect_valid) begin
                        r_pc <= redirect_target;
                    end
                    if (start) begin
                        r_state <= FS_RUN;
                    end
                end

                FS_RUN: begin
                    if (redirect_valid) begin
                        r_pc         <= redirect_target;
                        r_ifid_valid <= 1'b0;
                    end else if (flush) begin
                        r_ifid_valid <= 1'b0;
                        if (!stall) begin
                            r_pc <= w_pc_plus1;
                        end
                    end else if (!stall) begin
                        r_ifid_instr    <= instr_instruction;
                        r_ifid_pc       <= r_pc;
                        r_ifid_pc_plus1 <= w_pc_plus1;
                        r_ifid_valid    <= 1'b1;
                        r_fetch_count   <= sat_inc(r_fetch_count);
                        // The halt word is delivered to decode but the PC parks on it.
                        if (w_is_halt) begin
                            r_state <= FS_HALTED;
                        end else begin
                            r_pc <= w_pc_plus1;
                        end
                    end
                end

                FS_HALTED: begin
                    r_ifid_valid <= 1'b0;
                end

                default: begin
                    r_state      <= FS_IDLE;
                    r_ifid_valid <= 1'b0;
                end
            endcase
        end
    end

    assign instr_read_address = r_pc;
    assign ifid_instr         = r_ifid_instr;
    assign ifid_pc            = r_ifid_pc;
    assign ifid_pc_plus1      = r_ifid_pc_plus1;
    assign ifid_valid         = r_ifid_valid;
    assign running            = (r_state == FS_RUN);
    assign halted             = (r_state == FS_HALTED);
    assign fetch_count        = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// control traffic compared against a cycle-level behavioural model.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [ADDR_W-1:0]      instr_read_address;
    logic [WORD_SIZE-1:0]   instr_instruction;
    logic                   stall;
    logic                   flush;
    logic                   redirect_valid;
    logic [ADDR_W-1:0]      redirect_target;
    logic [WORD_SIZE-1:0]   ifid_instr;
    logic [ADDR_W-1:0]      ifid_pc;
    logic [ADDR_W-1:0]      ifid_pc_plus1;
    logic                   ifid_valid;
    logic                   running;
    logic                   halted;
    logic [FETCH_CNT_W-1:0] fetch_count;

    logic [WORD_SIZE-1:0] mem [256];

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: 0 = idle, 1 = run, 2 = halted
    int          m_st;
    logic [7:0]  m_pc;
    logic [31:0] m_instr;
    logic [7:0]  m_ipc;
    logic [7:0]  m_ipc1;
    logic        m_v;
    int          m_cnt;

    instr_fetch dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .instr_read_address (instr_read_address),
        .instr_instruction  (instr_instruction),
        .stall              (stall),
        .flush              (flush),
        .redirect_valid     (redirect_valid),
        .redirect_target    (redirect_target),
        .ifid_instr         (ifid_instr),
        .ifid_pc            (ifid_pc),
        .ifid_pc_plus1      (ifid_pc_plus1),
        .ifid_valid         (ifid_valid),
        .running            (running),
        .halted             (halted),
        .fetch_count        (fetch_count)
    );

    assign instr_instruction = mem[instr_read_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pc = 8'd0; m_instr = 32'd0; m_ipc = 8'd0; m_ipc1 = 8'd0;
        m_v = 1'b0; m_cnt = 0;
    endtask

    // One clock of the architectural rules, evaluated on the inputs about to be sampled.
    task automatic model_step();
        logic [31:0] w;
        if (m_st == 0) begin
            if (redirect_valid) m_pc = redirect_target;
            if (start) m_st = 1;
        end else if (m_st == 1) begin
            if (redirect_valid) begin
                m_pc = redirect_target;
                m_v = 1'b0;
            end else if (flush) begin
                m_v = 1'b0;
                if (!stall) m_pc = m_pc + 8'd1;
            end else if (!stall) begin
                w = mem[m_pc];
                m_instr = w;
                m_ipc = m_pc;
                m_ipc1 = m_pc + 8'd1;
                m_v = 1'b1;
                if (m_cnt < 65535) m_cnt++;
                if (w == HALT_WORD) m_st = 2;
                else m_pc = m_pc + 8'd1;
            end
        end else begin
            m_v = 1'b0;
        end
    endtask

    task automatic compare_all(input string p);
        check_eq({p, ".addr"},  32'(instr_read_address), 32'(m_pc));
        check_eq({p, ".instr"}, ifid_instr, m_instr);
        check_eq({p, ".ipc"},   32'(ifid_pc), 32'(m_ipc));
        check_eq({p, ".ipc1"},  32'(ifid_pc_plus1), 32'(m_ipc1));
        check_eq({p, ".vld"},   32'(ifid_valid), 32'(m_v));
        check_eq({p, ".run"},   32'(running), 32'(m_st == 1));
        check_eq({p, ".halt"},  32'(halted), 32'(m_st == 2));
        check_eq({p, ".cnt"},   32'(fetch_count), 32'(m_cnt));
    endtask

    task automatic set_in(input logic s, input logic st, input logic fl,
                          input logic rv, input logic [7:0] rt);
        start = s; stall = st; flush = fl; redirect_valid = rv; redirect_target = rt;
    endtask

    task automatic step(input string p, input bit chk);
        model_step();
        @(posedge clk);
        #1;
        if (chk) compare_all(p);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        #2;
        compare_all("rst_lo");
        @(posedge clk);
        #1;
        rst = 1'b1;
        compare_all("rst_rel");
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 8'd0);
        for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        #3;
        do_reset();
        check_eq("reset_addr", 32'(instr_read_address), 32'd0);
        check_eq("reset_cnt", 32'(fetch_count), 32'd0);

        // Sequential fetch of words 0..3
        set_in(1, 0, 0, 0, 8'd0);
        step("start", 1);
        set_in(0, 0, 0, 0, 8'd0);
        for (int i = 0; i < 4; i++) step("seq", 1);
        check_eq("seq_instr3", ifid_instr, 32'h44);
        check_eq("seq_pc3", 32'(ifid_pc), 32'd3);
        check_eq("seq_cnt4", 32'(fetch_count), 32'd4);

        // Stall held three cycles with PC = 5
        step("to5", 1);
        check_eq("pre_stall_addr", 32'(instr_read_address), 32'd5);
        set_in(0, 1, 0, 0, 8'd0);
        for (int i = 0; i < 3; i++) step("stall", 1);
        check_eq("stall_addr", 32'(instr_read_address), 32'd5);
        check_eq("stall_cnt", 32'(fetch_count), 32'd5);
        set_in(0, 0, 0, 0, 8'd0);
        step("resume", 1);
        check_eq("resume_pc", 32'(ifid_pc), 32'd5);

        // Redirect with simultaneous stall at PC = 10
        for (int i = 0; i < 20 && m_pc != 8'd10; i++) step("to10", 1);
        check_eq("at10", 32'(instr_read_address), 32'd10);
        set_in(0, 1, 0, 1, 8'h80);
        step("redir", 1);
        check_eq("redir_addr", 32'(instr_read_address), 32'h80);
        check_eq("redir_vld", 32'(ifid_valid), 32'd0);
        set_in(0, 0, 0, 0, 8'd0);
        step("redir_f", 1);
        check_eq("redir_ipc", 32'(ifid_pc), 32'h80);
        check_eq("redir_instr", ifid_instr, 32'h180);

        // PC wrap at 255
        set_in(0, 0, 0, 1, 8'd255);
        step("to255", 1);
        set_in(0, 0, 0, 0, 8'd0);
        step("wrap", 1);
        check_eq("wrap_ipc", 32'(ifid_pc), 32'd255);
        check_eq("wrap_ipc1", 32'(ifid_pc_plus1), 32'd0);
        check_eq("wrap_addr", 32'(instr_read_address), 32'd0);

        // Flush without stall advances PC, drops valid
        set_in(0, 0, 1, 0, 8'd0);
        step("flush", 1);
        check_eq("flush_vld", 32'(ifid_valid), 32'd0);
        check_eq("flush_addr", 32'(instr_read_address), 32'd1);

        // Halt word at address 7
        mem[7] = HALT_WORD;
        set_in(0, 0, 0, 1, 8'd7);
        step("to7", 1);
        set_in(0, 0, 0, 0, 8'd0);
        step("halt", 1);
        check_eq("halt_flag", 32'(halted), 32'd1);
        check_eq("halt_ipc", 32'(ifid_pc), 32'd7);
        check_eq("halt_vld", 32'(ifid_valid), 32'd1);
        check_eq("halt_addr", 32'(instr_read_address), 32'd7);
        for (int i = 0; i < 5; i++) begin
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 1, 8'($urandom));
            step("halted", 1);
        end
        set_in(0, 0, 0, 0, 8'd0);
        check_eq("halted_vld", 32'(ifid_valid), 32'd0);
        check_eq("halted_addr", 32'(instr_read_address), 32'd7);
        check_eq("halted_flag", 32'(halted), 32'd1);
        mem[7] = 32'h107;

        // Asynchronous reset between clock edges during RUN
        do_reset();
        set_in(1, 0, 0, 0, 8'd0);
        step("astart", 1);
        set_in(0, 0, 0, 0, 8'd0);
        for (int i = 0; i < 3; i++) step("arun", 1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        compare_all("async");
        check_eq("async_vld", 32'(ifid_valid), 32'd0);
        check_eq("async_run", 32'(running), 32'd0);
        check_eq("async_cnt", 32'(fetch_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("idle_hold", 1);
        check_eq("idle_addr", 32'(instr_read_address), 32'd0);
        set_in(1, 0, 0, 0, 8'd0);
        step("restart", 1);
        set_in(0, 0, 0, 0, 8'd0);
        step("refetch", 1);
        check_eq("refetch_instr", ifid_instr, 32'h11);

        // Randomized control traffic against the model
        for (int e = 0; e < 4; e++) begin
            for (int i = 0; i < 256; i++)
                mem[i] = ($urandom_range(0, 59) == 0) ? HALT_WORD : $urandom;
            do_reset();
            for (int c = 0; c < 250; c++) begin
                set_in($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                       8'($urandom));
                if (c == 0) start = 1'b1;
                step("rand", 1);
            end
        end

        // fetch_count saturation
        for (int i = 0; i < 256; i++) mem[i] = 32'h200 + i;
        set_in(0, 0, 0, 0, 8'd0);
        do_reset();
        set_in(1, 0, 0, 0, 8'd0);
        step("sat_start", 1);
        set_in(0, 0, 0, 0, 8'd0);
        for (int i = 0; i < 65540; i++) step("sat", 0);
        compare_all("sat");
        check_eq("sat_cnt", 32'(fetch_count), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the single-cycle/pipelined CPU. Owns the program counter, drives the word address into the 256-word unified instruction/data memory, and registers the returned 32-bit instruction into the IF/ID pipeline register for decode. Supports stall, flush, branch/jump redirect, a start handshake and a halt instruction.

## Interface
- WORD_SIZE, 32, instruction width in bits
- ADDR_W, 8, word-address width (256-word memory)
- RESET_PC, 0, PC value loaded on reset
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch

- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  single-cycle pulse; begins fetching from the current PC
- instr_read_address  output  ADDR_W  word address to memory; always equals PC
- instr_instruction  input  WORD_SIZE  combinational read data from memory
- stall  input  1  hold PC and IF/ID contents
- flush  input  1  invalidate IF/ID (insert bubble)
- redirect_valid  input  1  load PC with redirect_target
- redirect_target  input  ADDR_W  branch/jump target word address
- ifid_instr  output  WORD_SIZE  registered instruction
- ifid_pc  output  ADDR_W  address ifid_instr was fetched from
- ifid_pc_plus1  output  ADDR_W  ifid_pc + 1, modulo 2^ADDR_W
- ifid_valid  output  1  IF/ID holds a real instruction
- running  output  1  state == RUN
- halted  output  1  state == HALTED
- fetch_count  output  16  instructions captured since reset, saturates at 16'hFFFF

## Operation
- States: IDLE (reset), RUN, HALTED.
- IDLE: PC held, ifid_valid = 0. start -> RUN. redirect_valid in IDLE loads PC (boot-address set), stays IDLE.
- RUN, per cycle, priority highest first:
  - redirect_valid: PC <= redirect_target; ifid_valid <= 0 (stall ignored).
  - flush (no redirect): ifid_valid <= 0; PC advances by 1 unless stall.
  - stall: PC, ifid_* and fetch_count unchanged.
  - otherwise: capture ifid_instr <= instr_instruction, ifid_pc <= PC, ifid_pc_plus1 <= PC+1, ifid_valid <= 1, fetch_count++, PC <= PC+1.
- Halt: in the normal-capture case, if instr_instruction == HALT_WORD it is captured (valid = 1), PC is not advanced, state -> HALTED.
- HALTED: ifid_valid <= 0 next cycle and stays 0; PC frozen; start, stall, flush, redirect ignored. Exit only via reset.
- PC arithmetic modulo 2^ADDR_W: 255 + 1 = 0 (wrap, no error).
- fetch_count increments only on a valid capture; saturates.

## Timing
- Reset (rst = 0, asynchronous): PC = RESET_PC, state IDLE, ifid_instr = 0, ifid_pc = 0, ifid_pc_plus1 = 0, ifid_valid = 0, running = 0, halted = 0, fetch_count = 0. Release is synchronised by the clock edge; first RUN edge is the edge after start sampled high.
- instr_read_address is combinational from the PC register; memory returns data the same cycle.
- Latency: instruction at address A appears on ifid_instr with ifid_valid = 1 on the edge after the cycle PC == A (1 cycle).
- Redirect: target fetched the cycle after redirect_valid; first valid IF/ID from target 2 edges after redirect sampled.
- Throughput: one instruction per cycle absent stall/flush/redirect.
- Reset mid-operation: all state returns to reset values immediately, regardless of clk.

## Structure
- Shared package cpu_pkg: WORD_SIZE, ADDR_W, HALT_WORD, fetch state enum (IDLE/RUN/HALTED).
- Single module; no sub-module required. Next-PC mux and IF/ID register live in the same file.

## Test plan
- Reset then start with memory words 0..3 = 0x11,0x22,0x33,0x44 -> ifid_instr 0x11,0x22,0x33,0x44 on successive edges, ifid_pc 0,1,2,3, fetch_count 4.
- Stall held 3 cycles while PC = 5 -> instr_read_address stays 5, ifid_* unchanged, fetch_count unchanged; fetch resumes at 5.
- redirect_valid with target 0x80 and stall asserted together at PC = 10 -> next cycle PC = 0x80, ifid_valid = 0; following edge ifid_pc = 0x80.
- PC = 255, normal fetch -> ifid_pc = 255, ifid_pc_plus1 = 0, PC wraps to 0.
- HALT_WORD at address 7 -> captured with ifid_pc = 7, halted = 1, PC stays 7, ifid_valid = 0 thereafter; start/redirect ignored.
- rst driven low between clock edges during RUN -> outputs at reset values without waiting for clk; start required again to fetch.
